// File: rtl/shared_counter_ctrl.sv
// ---------------------------------------------------------------------------
// shared_counter_ctrl
//
// Sequencer/arbiter for one wide counter built from NUM_SUB slices of
// GRANULARITY bits each (slice 0 least significant). Requesters issue reset,
// increment, query or load operations. Grants are round-robin. Increments
// ripple their carry through the slices at one slice per cycle.
//
// Optional feature macro: CTRL_SATURATE_EN
//   undefined : increment of an all-ones counter wraps to zero, wrap_out=1
//   defined   : increment of an all-ones counter issues no slice command,
//               counter stays all ones, wrap_out=1 (saturated)
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   req              per-requester request, held until its gnt bit pulses
//   op_in            per-requester op [2i+1:2i]: 00 rst, 01 inc, 10 query, 11 load
//   load_data_in     per-requester load value [W*i+W-1:W*i]
//   count_in         concatenated slice outputs
//   sub_command_out  per-slice command: 00 rst, 01 inc, 10 idle, 11 load
//   load_data_out    load value presented to the slices
//   gnt              one-hot grant pulse
//   busy             controller not idle
//   done             one-cycle completion pulse
//   done_id          requester index that completed (valid with done)
//   result_out       counter value after the operation (valid with done)
//   wrap_out         increment wrapped / saturated (valid with done)
// ---------------------------------------------------------------------------
module shared_counter_ctrl #(
  parameter int GRANULARITY = 4,
  parameter int NUM_SUB     = 2,
  parameter int NUM_REQ     = 3,
  localparam int W          = GRANULARITY * NUM_SUB,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   op_in,
  input  logic [W*NUM_REQ-1:0]   load_data_in,
  input  logic [W-1:0]           count_in,
  output logic [2*NUM_SUB-1:0]   sub_command_out,
  output logic [W-1:0]           load_data_out,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [W-1:0]           result_out,
  output logic                   wrap_out
);

  localparam int KW = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;

  localparam logic [1:0] OP_RST   = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_QRY   = 2'b10;
  localparam logic [1:0] OP_LD    = 2'b11;

  localparam logic [1:0] CMD_RST  = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_IDLE = 2'b10;
  localparam logic [1:0] CMD_LD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDW-1:0]         r_rr_ptr;
  logic [IDW-1:0]         r_id;
  logic [1:0]             r_op;
  logic [KW-1:0]          r_k;
  logic [W-1:0]           r_ldata;
  logic                   r_wrap;

  logic                   w_win_vld;
  logic [IDW-1:0]         w_win_id;
  logic [1:0]             w_win_op;
  logic [GRANULARITY-1:0] w_slice;
  logic                   w_slice_ones;
  logic                   w_last;
  logic                   w_k_adv;
  logic                   w_wrap_set;
  logic [2*NUM_SUB-1:0]   w_sub_cmd;
`ifdef CTRL_SATURATE_EN
  logic                   w_full;
  assign w_full = &count_in;
`endif

  // Round-robin search: walk downward so the lowest offset from r_rr_ptr
  // is the last assignment and therefore wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[(int'(r_rr_ptr) + j) % NUM_REQ]) begin
        w_win_vld = 1'b1;
        w_win_id  = IDW'((int'(r_rr_ptr) + j) % NUM_REQ);
      end
    end
  end

  assign w_win_op     = op_in[2*int'(w_win_id) +: 2];
  assign w_slice      = count_in[GRANULARITY*int'(r_k) +: GRANULARITY];
  assign w_slice_ones = &w_slice;
  assign w_last       = (int'(r_k) == NUM_SUB - 1);

  // State register and latched operation context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_op     <= OP_QRY;
      r_k      <= '0;
      r_ldata  <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_win_vld) begin
        r_op     <= w_win_op;
        r_id     <= w_win_id;
        r_k      <= '0;
        r_wrap   <= 1'b0;
        r_rr_ptr <= (int'(w_win_id) == NUM_REQ - 1) ? '0 : w_win_id + 1'b1;
        // Only a load changes what the slices see on load_data_out; other
        // ops leave the previous load value in place.
        if (w_win_op == OP_LD) begin
          r_ldata <= load_data_in[W*int'(w_win_id) +: W];
        end
      end
      if (w_k_adv) begin
        r_k <= r_k + 1'b1;
      end
      if (w_wrap_set) begin
        r_wrap <= 1'b1;
      end
    end
  end

  // Next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_sub_cmd   = {NUM_SUB{CMD_IDLE}};
    w_k_adv     = 1'b0;
    w_wrap_set  = 1'b0;
    gnt         = '0;
    done        = 1'b0;
    done_id     = '0;
    result_out  = '0;
    wrap_out    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          gnt[w_win_id] = 1'b1;
          w_state_nxt   = S_EXEC;
        end
      end

      S_EXEC: begin
        case (r_op)
          OP_RST: begin
            w_sub_cmd   = {NUM_SUB{CMD_RST}};
            w_state_nxt = S_DONE;
          end
          OP_LD: begin
            w_sub_cmd   = {NUM_SUB{CMD_LD}};
            w_state_nxt = S_DONE;
          end
          OP_INC: begin
`ifdef CTRL_SATURATE_EN
            // Full counter already all ones: leave every slice idle.
            if (w_full) begin
              w_wrap_set  = 1'b1;
              w_state_nxt = S_DONE;
            end else
`endif
            begin
              w_sub_cmd[2*int'(r_k) +: 2] = CMD_INC;
              // Slice k rolls over at this edge, so the carry moves up.
              if (w_slice_ones && !w_last) begin
                w_k_adv = 1'b1;
              end else begin
                w_state_nxt = S_DONE;
                if (w_slice_ones) begin
                  w_wrap_set = 1'b1;
                end
              end
            end
          end
          default: begin
            w_state_nxt = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        done        = 1'b1;
        done_id     = r_id;
        result_out  = count_in;
        wrap_out    = r_wrap;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign sub_command_out = w_sub_cmd;
  assign load_data_out   = r_ldata;
  assign busy            = (r_state != S_IDLE);

endmodule
